div_int_unit: RTL and testbench

Sequential unsigned integer divider. Computes quotient and remainder of x / y one quotient bit per clock (restoring shift-subtract). Flags divide-by-zero. Used as a small multi-cycle arithmetic unit behind a start/busy/valid handshake.

---
 rtl/div_int_unit.sv | 120 ++++++++++++
 tb/tb_div_int_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_int_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_int_unit
// Brief    : Sequential unsigned integer divider (restoring shift-subtract).
//            One quotient bit per clock behind a start/busy/valid handshake;
//            flags divide-by-zero with a one-edge response.
// Revision : 1.0 - initial release
// ============================================================================
module div_int_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  // Counter just wide enough to reach WIDTH-1.
  localparam int              CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   acc_q;     // partial remainder plus next dividend bit
  logic [WIDTH-1:0] quo_q;     // remaining dividend bits on top, quotient bits shifted in below
  logic [WIDTH-1:0] div_q;     // captured divisor
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic             dbz_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;

  logic             ge_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] quo_d;
  logic             unused_rem_msb;

  // One restoring step: trial subtract, pick remainder, shift in next dividend bit.
  always_comb begin
    ge_d  = (acc_q >= {1'b0, div_q});
    rem_d = ge_d ? (acc_q - {1'b0, div_q}) : acc_q;
    // The partial remainder is always below the divisor, so its top bit is zero.
    acc_d = {rem_d[WIDTH-1:0], quo_q[WIDTH-1]};
    quo_d = {quo_q[WIDTH-2:0], ge_d};
  end

  assign unused_rem_msb = rem_d[WIDTH];

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (y == '0) begin
              dbz_q   <= 1'b1;
              valid_q <= 1'b0;
              q_q     <= '0;
              r_q     <= '0;
            end else begin
              div_q   <= y;
              acc_q   <= {{WIDTH{1'b0}}, x[WIDTH-1]};
              quo_q   <= {x[WIDTH-2:0], 1'b0};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
              dbz_q   <= 1'b0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + C_ONE;
          if (cnt_q == C_LAST) begin
            q_q     <= quo_d;
            r_q     <= rem_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign dbz   = dbz_q;
  assign q     = q_q;
  assign r     = r_q;

endmodule
`default_nettype wire

// File: tb/tb_div_int_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_int_unit
// Brief    : Directed self-checking bench for div_int_unit (WIDTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_int_unit;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             valid;
  logic             dbz;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  int vectors;
  int miscompares;

  div_int_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .valid (valid),
    .dbz   (dbz),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
    x     = xv;
    y     = yv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // From just after the start edge, count edges until valid and busy-high samples.
  task automatic measure(output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (!valid && edges < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    int e, b;
    vectors++;
    if ({busy, valid, dbz, q, r} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got {busy,valid,dbz,q,r}=%b want all zero", {busy, valid, dbz, q, r});
    end
    // Leave a nonzero result behind so the mid-calculation reset has something to clear.
    launch(4'd7, 4'd2);
    measure(e, b);
    launch(4'd15, 4'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, valid, dbz, q, r} !== '0) begin
      miscompares++;
      $display("FAIL reset_midcalc: got {busy,valid,dbz,q,r}=%b want all zero", {busy, valid, dbz, q, r});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0] tx [5] = '{4'd0, 4'd7, 4'd15, 4'd1, 4'd8};
    logic [WIDTH-1:0] ty [5] = '{4'd2, 4'd2, 4'd5,  4'd1, 4'd9};
    logic [WIDTH-1:0] eq [5] = '{4'd0, 4'd3, 4'd3,  4'd1, 4'd0};
    logic [WIDTH-1:0] er [5] = '{4'd0, 4'd1, 4'd0,  4'd0, 4'd8};
    int e, b;
    for (int i = 0; i < 5; i++) begin
      launch(tx[i], ty[i]);
      measure(e, b);
      vectors++;
      if ({valid, dbz, busy, q, r} !== {1'b1, 1'b0, 1'b0, eq[i], er[i]}) begin
        miscompares++;
        $display("FAIL basic_%0d_%0d: got valid=%b dbz=%b busy=%b q=%0d r=%0d want 1 0 0 q=%0d r=%0d",
                 tx[i], ty[i], valid, dbz, busy, q, r, eq[i], er[i]);
      end
      vectors++;
      if (e !== 4 || b !== 4) begin
        miscompares++;
        $display("FAIL latency_%0d_%0d: got valid after %0d edges busy %0d cycles want 4 and 4",
                 tx[i], ty[i], e, b);
      end
    end
  endtask

  task automatic test_dbz;
    int e, b;
    launch(4'd2, 4'd0);
    vectors++;
    if ({dbz, valid, busy, q, r} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL dbz_2_0: got dbz=%b valid=%b busy=%b q=%0d r=%0d want 1 0 0 0 0", dbz, valid, busy, q, r);
    end
    // Levels must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({dbz, valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL dbz_hold: got dbz=%b valid=%b want 1 0", dbz, valid);
    end
    launch(4'd7, 4'd2);
    vectors++;
    if ({dbz, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL dbz_clear_on_start: got dbz=%b busy=%b want 0 1", dbz, busy);
    end
    measure(e, b);
    vectors++;
    if ({valid, dbz, q, r} !== {1'b1, 1'b0, 4'd3, 4'd1}) begin
      miscompares++;
      $display("FAIL dbz_then_7_2: got valid=%b dbz=%b q=%0d r=%0d want 1 0 3 1", valid, dbz, q, r);
    end
  endtask

  task automatic test_start_busy;
    int e, b;
    launch(4'd15, 4'd5);
    e = 0;
    b = 0;
    while (!valid && e < 20) begin
      if (busy) b++;
      if (e == 1) begin
        x     = 4'd1;
        y     = 4'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    vectors++;
    if ({valid, q, r} !== {1'b1, 4'd3, 4'd0} || e !== 4 || b !== 4) begin
      miscompares++;
      $display("FAIL start_while_busy: got valid=%b q=%0d r=%0d edges=%0d busy=%0d want 1 3 0 4 4",
               valid, q, r, e, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] eq, er;
    int e;
    start = 1'b1;
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        x = xi[WIDTH-1:0];
        y = yi[WIDTH-1:0];
        @(posedge clk);
        #1;
        if (yi == 0) begin
          vectors++;
          if ({dbz, valid, busy, q, r} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL exh_%0d_0: got dbz=%b valid=%b busy=%b q=%0d r=%0d want 1 0 0 0 0",
                     xi, dbz, valid, busy, q, r);
          end
        end else begin
          eq = 4'(xi / yi);
          er = 4'(xi % yi);
          vectors++;
          if ({busy, valid, dbz} !== 3'b100) begin
            miscompares++;
            $display("FAIL exh_accept_%0d_%0d: got busy=%b valid=%b dbz=%b want 1 0 0",
                     xi, yi, busy, valid, dbz);
          end
          e = 0;
          while (!valid && e < 20) begin
            @(posedge clk);
            #1;
            e++;
          end
          vectors++;
          if ({valid, dbz, q, r} !== {1'b1, 1'b0, eq, er} || e !== 4) begin
            miscompares++;
            $display("FAIL exh_%0d_%0d: got valid=%b dbz=%b q=%0d r=%0d edges=%0d want 1 0 %0d %0d 4",
                     xi, yi, valid, dbz, q, r, e, eq, er);
          end
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    x           = '0;
    y           = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_dbz;
    test_start_busy;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
